reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Consumes the free-running 13-bit pseudo-random value (nominally 1000..3001) as a millisecond delay for one round of the reaction game.
- On Start: latches the value, waits that many ms, lights the stimulus LED, then counts ms until the player's button rising edge.
- Reports the reaction time in ms, or flags an early press or a timeout.
- Feeds the display/score stage downstream.

Parameters:
- CYCLES_PER_MS, 100000: Clk cycles per 1 ms tick (100 MHz board clock).
- MAX_MS, 9999: reaction count ceiling (4-digit display); reaching it is a timeout.
- DELAY_W, 13: width of RandomValue input.
- RT_W, 14: width of ReactionMs; must hold MAX_MS.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse, already synchronized and debounced; begins a round.
- Button  in  1  player button level, already synchronized and debounced.
- RandomValue  in  DELAY_W  delay in ms, sampled only on an accepted Start.
- LedOn  out  1  stimulus LED; high only in MEASURE.
- ReactionMs  out  RT_W  running/final reaction count in ms.
- ResultValid  out  1  high while in DONE.
- EarlyPress  out  1  high while in EARLY.
- Timeout  out  1  high while in TIMEOUT.
- Busy  out  1  high in WAIT or MEASURE.

Behaviour:
- Reset (Rst low, async): state IDLE; all outputs 0; delay counter, prescaler and button edge register cleared.
- ms tick: prescaler counts 0..CYCLES_PER_MS-1 and asserts a 1-cycle tick on the wrap. It is cleared on every state entry, so the first tick arrives exactly CYCLES_PER_MS cycles after entry.
- Button edge: rise = Button & ~Button_q. Button_q updates every cycle, in all states.
- States:
  - IDLE: outputs 0. On Start: DelayCnt <= RandomValue, or 1 if RandomValue == 0. Next state WAIT.
  - WAIT: Busy=1. On tick: DelayCnt decrements. If rise occurs → EARLY; rise has priority over a same-cycle tick. When tick and DelayCnt == 1 → MEASURE, with ReactionMs <= 0. LedOn is asserted the cycle after the final tick.
  - MEASURE: LedOn=1, Busy=1. On tick: ReactionMs increments.
    - rise → DONE. ReactionMs is frozen at its current value; a same-cycle tick's increment is dropped.
    - Tick taking ReactionMs to MAX_MS → TIMEOUT with ReactionMs = MAX_MS.
    - A Button held high on entry does not count; a fresh rising edge is required.
  - DONE / EARLY / TIMEOUT: hold their flag and ReactionMs (EARLY and TIMEOUT also hold ReactionMs; it is 0 in EARLY). On Start → behave as IDLE+Start in the same cycle, i.e. re-latch RandomValue, clear flags and ReactionMs, go to WAIT.
- Start is ignored in WAIT and MEASURE.
- Total delay: exactly DelayCnt*CYCLES_PER_MS cycles from WAIT entry to MEASURE entry.
- Exactly one of ResultValid/EarlyPress/Timeout is high in terminal states; none elsewhere.
- Reset mid-round: immediate return to IDLE, LedOn drops asynchronously.
- Arithmetic is unsigned. No wrap is possible: DelayCnt stops at 1→0 transition, and ReactionMs is capped at MAX_MS.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, MEASURE, DONE, EARLY, TIMEOUT), MS_CYCLES_100MHZ = 100000, MAX_DISPLAY_MS = 9999.
- One sub-module: ms_tick_gen (prescaler with sync clear input, 1-cycle tick output), reusable by the display refresh stage.

Test Plan (CYCLES_PER_MS=4, MAX_MS=50 in sim):
- Normal round: RandomValue=3, Start, rise at 4 ms after LedOn → LedOn rises 12 cycles after WAIT entry; ResultValid=1, ReactionMs=4, LedOn=0.
- Early press: RandomValue=5, rise after 2 ticks in WAIT → EarlyPress=1, LedOn never asserted, ReactionMs=0.
- Timeout: RandomValue=1, no press → Timeout=1 after 50 ticks in MEASURE, ReactionMs=50.
- Button held through LedOn and released/re-pressed after 3 ticks → only the re-press counts; ResultValid with ReactionMs=3. RandomValue=0 → treated as 1 ms delay.
- Tick and rise in the same cycle in MEASURE at count 6 → ReactionMs=6. Start pulses during WAIT are ignored. Start in DONE relatches new RandomValue=2 and restarts.
- Rst low mid-MEASURE → LedOn and all outputs 0 immediately; after release, IDLE with Start required.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction game: round states and board-level
// default constants (1 ms at 100 MHz, 4-digit display ceiling).
// Ports: none (package).
package reaction_timer_pkg;

   // Round states: idle, random pre-delay, LED lit and counting, and the
   // three terminal outcomes that hold their result until the next Start.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DONE    = 3'd3,
      ST_EARLY   = 3'd4,
      ST_TIMEOUT = 3'd5
   } rtState_e;

   localparam int MS_CYCLES_100MHZ = 100000;
   localparam int MAX_DISPLAY_MS   = 9999;

endpackage

// File: rtl/reaction_timer_if.sv
// Bundle of the reaction timer's game-side signals.
// Ports (signals):
//   Start       - one-cycle round start pulse (synchronized, debounced)
//   Button      - player button level (synchronized, debounced)
//   RandomValue - pre-delay in ms, sampled on an accepted Start
//   LedOn       - stimulus LED
//   ReactionMs  - running/final reaction count in ms
//   ResultValid - round finished with a valid reaction time
//   EarlyPress  - player pressed before the LED lit
//   Timeout     - reaction count reached its ceiling
//   Busy        - a round is in progress
// Modports: master drives the game inputs, slave is the timer itself.
interface reaction_timer_if #(
   parameter int DELAY_W = 13,
   parameter int RT_W    = 14
);
   logic               Start;
   logic               Button;
   logic [DELAY_W-1:0] RandomValue;
   logic               LedOn;
   logic [RT_W-1:0]    ReactionMs;
   logic               ResultValid;
   logic               EarlyPress;
   logic               Timeout;
   logic               Busy;

   modport master (
      output Start, Button, RandomValue,
      input  LedOn, ReactionMs, ResultValid, EarlyPress, Timeout, Busy
   );

   modport slave (
      input  Start, Button, RandomValue,
      output LedOn, ReactionMs, ResultValid, EarlyPress, Timeout, Busy
   );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..CYCLES_PER_MS-1 and raises tick for one
// cycle while sitting on the last count. A synchronous clear restarts the
// count so the first tick lands exactly CYCLES_PER_MS cycles later.
// Ports:
//   Clk   - clock, rising edge
//   Rst   - asynchronous active-low reset
//   clear - synchronous restart of the count
//   tick  - one-cycle pulse once per CYCLES_PER_MS cycles
module ms_tick_gen
   import reaction_timer_pkg::*;
#(
   parameter int CYCLES_PER_MS = MS_CYCLES_100MHZ
) (
   input  logic Clk,
   input  logic Rst,
   input  logic clear,
   output logic tick
);
   localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_MS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The tick is decoded from the registered count so it never depends on
   // clear; a clear in the tick cycle still lets that tick be consumed.
   assign tick = (cnt_q == LAST);

   // Next count: clear wins, otherwise wrap on the last value or advance.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Prescaler register, cleared by reset.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/reaction_timer.sv
// Reaction game round controller. On Start it latches a random delay in ms,
// waits it out, lights the LED, then counts ms until a fresh button press.
// A press before the LED is an early press; reaching MAX_MS is a timeout.
// Ports:
//   Clk - clock, rising edge
//   Rst - asynchronous active-low reset
//   bus - game signals (slave side), see reaction_timer_if
module reaction_timer
   import reaction_timer_pkg::*;
#(
   parameter int CYCLES_PER_MS = MS_CYCLES_100MHZ,
   parameter int MAX_MS        = MAX_DISPLAY_MS,
   parameter int DELAY_W       = 13,
   parameter int RT_W          = 14
) (
   input  logic          Clk,
   input  logic          Rst,
   reaction_timer_if.slave bus
);
   localparam logic [RT_W-1:0] MAX_VAL    = RT_W'(MAX_MS);
   localparam logic [RT_W-1:0] MAX_MINUS1 = RT_W'(MAX_MS - 1);

   rtState_e           state_q, state_d;
   logic [DELAY_W-1:0] delayCnt_q, delayCnt_d;
   logic [RT_W-1:0]    reactionMs_q, reactionMs_d;
   logic               button_q;
   logic               rise;
   logic               tick;
   logic               clearTick;

   // Only a fresh rising edge counts as a press, so a button already held
   // when the LED lights is ignored until it is released and pressed again.
   assign rise = bus.Button & ~button_q;

   // Restart the ms prescaler on every state change so each state's first
   // tick arrives a full millisecond after entry.
   assign clearTick = (state_d != state_q);

   ms_tick_gen #(
      .CYCLES_PER_MS(CYCLES_PER_MS)
   ) u_tick (
      .Clk  (Clk),
      .Rst  (Rst),
      .clear(clearTick),
      .tick (tick)
   );

   // Next-state logic. Terminal states accept Start exactly like IDLE, so a
   // new round can begin directly from a displayed result. In both active
   // states a press beats a same-cycle tick.
   always_comb begin
      state_d      = state_q;
      delayCnt_d   = delayCnt_q;
      reactionMs_d = reactionMs_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: begin
            if (bus.Start) begin
               state_d      = ST_WAIT;
               delayCnt_d   = (bus.RandomValue == '0) ? DELAY_W'(1) : bus.RandomValue;
               reactionMs_d = '0;
            end
         end
         ST_WAIT: begin
            if (rise) begin
               state_d = ST_EARLY;
            end else if (tick) begin
               delayCnt_d = delayCnt_q - DELAY_W'(1);
               if (delayCnt_q == DELAY_W'(1)) begin
                  state_d      = ST_MEASURE;
                  reactionMs_d = '0;
               end
            end
         end
         ST_MEASURE: begin
            if (rise) begin
               state_d = ST_DONE;
            end else if (tick) begin
               if (reactionMs_q == MAX_MINUS1) begin
                  state_d      = ST_TIMEOUT;
                  reactionMs_d = MAX_VAL;
               end else begin
                  reactionMs_d = reactionMs_q + RT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and the button history register. The button history
   // tracks every cycle regardless of state.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q      <= ST_IDLE;
         delayCnt_q   <= '0;
         reactionMs_q <= '0;
         button_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         delayCnt_q   <= delayCnt_d;
         reactionMs_q <= reactionMs_d;
         button_q     <= bus.Button;
      end
   end

   // Outputs decode straight from the state register, so reset drops the
   // LED immediately without waiting for a clock.
   assign bus.LedOn       = (state_q == ST_MEASURE);
   assign bus.Busy        = (state_q == ST_WAIT) || (state_q == ST_MEASURE);
   assign bus.ResultValid = (state_q == ST_DONE);
   assign bus.EarlyPress  = (state_q == ST_EARLY);
   assign bus.Timeout     = (state_q == ST_TIMEOUT);
   assign bus.ReactionMs  = reactionMs_q;
endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer with a 4-cycle ms and a 50 ms
// ceiling. A timestamp-based model predicts every output each cycle; the
// directed rounds also pin key results to hand-computed constants.
module tb_reaction_timer;
   localparam int N      = 4;
   localparam int MAXMS  = 50;

   localparam int M_IDLE    = 0;
   localparam int M_RUN     = 1;
   localparam int M_DONE    = 2;
   localparam int M_EARLY   = 3;
   localparam int M_TIMEOUT = 4;

   logic Clk;
   logic Rst;

   reaction_timer_if #(.DELAY_W(13), .RT_W(14)) bus ();

   reaction_timer #(
      .CYCLES_PER_MS(N),
      .MAX_MS       (MAXMS),
      .DELAY_W      (13),
      .RT_W         (14)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: a round is described by the edge it started on and its delay;
   // LED and timeout edges follow by arithmetic.
   longint k        = 0;
   int     mode     = M_IDLE;
   longint startEdge = 0;
   longint delayMs  = 0;
   longint heldMs   = 0;
   logic   prevB    = 1'b0;
   logic   ledSeen  = 1'b0;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model update on each active edge, reset asynchronously like the DUT.
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         mode  = M_IDLE;
         prevB = 1'b0;
         heldMs = 0;
      end else begin
         longint ledEdge;
         logic   rise;
         k++;
         rise  = bus.Button && !prevB;
         prevB = bus.Button;
         ledEdge = startEdge + delayMs * N;
         if (mode != M_RUN) begin
            if (bus.Start) begin
               mode      = M_RUN;
               startEdge = k;
               delayMs   = (bus.RandomValue == 0) ? 1 : longint'(bus.RandomValue);
               heldMs    = 0;
            end
         end else if (rise) begin
            if (k <= ledEdge) begin
               mode   = M_EARLY;
               heldMs = 0;
            end else begin
               mode   = M_DONE;
               heldMs = (k - ledEdge - 1) / N;
            end
         end else if (k == ledEdge + MAXMS * N) begin
            mode   = M_TIMEOUT;
            heldMs = MAXMS;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge Clk) begin
      longint ledEdge;
      longint expMs;
      logic   expLed;
      ledEdge = startEdge + delayMs * N;
      expLed  = (mode == M_RUN) && (k >= ledEdge);
      if (mode == M_RUN) expMs = expLed ? (k - ledEdge) / N : 0;
      else               expMs = heldMs;
      checkOutput("model_led",     bus.LedOn,       expLed);
      checkOutput("model_busy",    bus.Busy,        mode == M_RUN);
      checkOutput("model_valid",   bus.ResultValid, mode == M_DONE);
      checkOutput("model_early",   bus.EarlyPress,  mode == M_EARLY);
      checkOutput("model_timeout", bus.Timeout,     mode == M_TIMEOUT);
      checkOutput("model_ms",      bus.ReactionMs,  expMs);
   end

   // Drive one cycle of inputs; they are sampled on the next rising edge.
   task automatic applyStimulus(input logic s, input logic b, input int rv);
      bus.Start       = s;
      bus.Button      = b;
      bus.RandomValue = 13'(rv);
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      if (bus.LedOn) ledSeen = 1'b1;
   endtask

   task automatic waitForLed(input logic b, input logic spamStart, output int n);
      n = 0;
      while (!bus.LedOn && n < 300) begin
         applyStimulus(spamStart && (n % 3 == 1), b, 7);
         n++;
      end
   endtask

   initial begin
      int n;
      int periods[3];
      periods = '{0, 25, 300};
      bus.Start       = 1'b0;
      bus.Button      = 1'b0;
      bus.RandomValue = '0;
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("reset_led",  bus.LedOn, 0);
      checkOutput("reset_busy", bus.Busy, 0);
      checkOutput("reset_ms",   bus.ReactionMs, 0);
      Rst = 1'b1;
      applyStimulus(0, 0, 0);

      // Normal round: 3 ms delay, press after 4 ticks of LED.
      applyStimulus(1, 0, 3);
      checkOutput("normal_busy", bus.Busy, 1);
      waitForLed(0, 0, n);
      checkOutput("normal_led_delay", n, 12);
      repeat (16) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("normal_valid", bus.ResultValid, 1);
      checkOutput("normal_ms",    bus.ReactionMs, 4);
      checkOutput("normal_led",   bus.LedOn, 0);

      // Early press after 2 ticks of a 5 ms delay.
      applyStimulus(0, 0, 0);
      ledSeen = 1'b0;
      applyStimulus(1, 0, 5);
      repeat (8) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("early_flag",     bus.EarlyPress, 1);
      checkOutput("early_ms",       bus.ReactionMs, 0);
      checkOutput("early_led_seen", ledSeen, 0);

      // Timeout: 1 ms delay, then 50 ms with no press.
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 1);
      n = 0;
      while (!bus.Timeout && n < 400) begin
         applyStimulus(0, 0, 0);
         n++;
      end
      checkOutput("timeout_edges", n, 204);
      checkOutput("timeout_ms",    bus.ReactionMs, 50);
      checkOutput("timeout_valid", bus.ResultValid, 0);

      // Held button through LED, zero delay treated as 1 ms, re-press counts.
      applyStimulus(1, 1, 0);
      waitForLed(1, 0, n);
      checkOutput("held_led_delay", n, 4);
      repeat (12) applyStimulus(0, 1, 0);
      checkOutput("held_still_busy", bus.Busy, 1);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("held_valid", bus.ResultValid, 1);
      checkOutput("held_ms",    bus.ReactionMs, 3);

      // Start from DONE with 2 ms, Starts during WAIT ignored, press on the
      // tick that would reach 7.
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 2);
      waitForLed(0, 1, n);
      checkOutput("restart_led_delay", n, 8);
      repeat (27) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("tickrise_valid", bus.ResultValid, 1);
      checkOutput("tickrise_ms",    bus.ReactionMs, 6);

      // Asynchronous reset in the middle of MEASURE.
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 1);
      waitForLed(0, 0, n);
      repeat (5) applyStimulus(0, 0, 0);
      #2 Rst = 1'b0;
      #1;
      checkOutput("rst_led",  bus.LedOn, 0);
      checkOutput("rst_busy", bus.Busy, 0);
      checkOutput("rst_ms",   bus.ReactionMs, 0);
      @(posedge Clk);
      #1 Rst = 1'b1;
      repeat (3) applyStimulus(0, 0, 0);
      checkOutput("post_rst_idle", bus.Busy, 0);
      applyStimulus(1, 0, 2);
      checkOutput("post_rst_start", bus.Busy, 1);

      // Randomized play with varying press rates.
      for (int seg = 0; seg < 30; seg++) begin
         int per;
         logic b;
         per = periods[$urandom_range(0, 2)];
         b   = bus.Button;
         for (int c = 0; c < 200; c++) begin
            if (per != 0 && $urandom_range(0, per - 1) == 0) b = ~b;
            applyStimulus($urandom_range(0, 39) == 0, b, int'($urandom_range(0, 6)));
         end
      end

      @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
